// File: rtl/palette_fade_ram.sv
`default_nettype none
// ============================================================================
// Module   : palette_fade_ram
// Purpose  : Palette RAM with a two-stage lookup that scales by a fade level.
// Revision : 1.0  initial release
// ============================================================================
module palette_fade_ram #(
    parameter int IDX_W = 4,
    parameter int CH_W  = 4,
    parameter int LVL_W = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_index,
    input  logic [3*CH_W-1:0]  wr_rgb,
    input  logic               rd_valid,
    input  logic [IDX_W-1:0]   rd_index,
    output logic               out_valid,
    output logic [CH_W-1:0]    red,
    output logic [CH_W-1:0]    green,
    output logic [CH_W-1:0]    blue,
    input  logic               frame_tick,
    input  logic [1:0]         fade_cmd,
    input  logic [7:0]         fade_rate,
    output logic [LVL_W:0]     level,
    output logic               busy,
    output logic               fade_done
);

    localparam int            c_DEPTH    = 1 << IDX_W;
    localparam int            c_RGB_W    = 3 * CH_W;
    localparam int            c_PROD_W   = CH_W + LVL_W + 1;
    localparam logic [LVL_W:0] c_FULL    = {1'b1, {LVL_W{1'b0}}};
    localparam logic [LVL_W:0] c_ZERO    = '0;

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_FADE_OUT = 2'd1;
    localparam logic [1:0] c_FADE_IN  = 2'd2;

    localparam logic [1:0] c_CMD_OUT  = 2'b01;
    localparam logic [1:0] c_CMD_IN   = 2'b10;
    localparam logic [1:0] c_CMD_SNAP = 2'b11;

    logic [c_RGB_W-1:0] r_pal [c_DEPTH];
    logic [c_RGB_W-1:0] w_rd_data;
    logic               r_s1_valid;
    logic [c_RGB_W-1:0] r_s1_rgb;
    logic [CH_W-1:0]    w_scaled [3];
    logic               r_out_valid;
    logic [CH_W-1:0]    r_red;
    logic [CH_W-1:0]    r_green;
    logic [CH_W-1:0]    r_blue;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               w_busy;
    logic [7:0]         r_tick;
    logic [LVL_W:0]     r_level;
    logic               r_done;
    logic [7:0]         w_rate;
    logic               w_rate_hit;
    logic               w_step;
    logic [LVL_W:0]     w_level_step;
    logic [LVL_W:0]     w_target;
    logic               w_reach;
    logic               w_snap;
    logic               w_start;
    logic               w_noop_done;

    // ------------------------------------------------------------------
    // Palette storage and lookup pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_pal[i] <= '0;
            end
        end else if (wr_en) begin
            r_pal[wr_index] <= wr_rgb;
        end
    end

    // Same-cycle write to the requested index wins over the stored entry
    assign w_rd_data = (wr_en && (wr_index == rd_index)) ? wr_rgb : r_pal[rd_index];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_rgb   <= '0;
        end else begin
            r_s1_valid <= rd_valid;
            if (rd_valid) begin
                r_s1_rgb <= w_rd_data;
            end
        end
    end

    // Channel 0 is blue, 1 green, 2 red
    for (genvar k = 0; k < 3; k++) begin : g_ch
        logic [c_PROD_W-1:0] w_prod;
        assign w_prod      = {{(LVL_W+1){1'b0}}, r_s1_rgb[k*CH_W +: CH_W]}
                           * {{CH_W{1'b0}}, r_level};
        assign w_scaled[k] = w_prod[LVL_W +: CH_W];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_out_valid <= 1'b0;
            r_red       <= '0;
            r_green     <= '0;
            r_blue      <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_red   <= w_scaled[2];
                r_green <= w_scaled[1];
                r_blue  <= w_scaled[0];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign red       = r_red;
    assign green     = r_green;
    assign blue      = r_blue;

    // ------------------------------------------------------------------
    // Fade controller
    // ------------------------------------------------------------------
    assign w_snap       = (fade_cmd == c_CMD_SNAP);
    assign w_rate       = (fade_rate == 8'd0) ? 8'd1 : fade_rate;
    assign w_rate_hit   = frame_tick && (({1'b0, r_tick} + 9'd1) >= {1'b0, w_rate});
    assign w_step       = w_busy && w_rate_hit;
    assign w_level_step = (r_state == c_FADE_OUT) ? (r_level - 1'b1) : (r_level + 1'b1);
    assign w_target     = (r_state == c_FADE_OUT) ? c_ZERO : c_FULL;
    assign w_reach      = w_step && (w_level_step == w_target);
    assign w_start      = (r_state == c_IDLE)
                        && (((fade_cmd == c_CMD_OUT) && (r_level != c_ZERO))
                         || ((fade_cmd == c_CMD_IN)  && (r_level != c_FULL)));
    assign w_noop_done  = (r_state == c_IDLE)
                        && (((fade_cmd == c_CMD_OUT) && (r_level == c_ZERO))
                         || ((fade_cmd == c_CMD_IN)  && (r_level == c_FULL)));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_snap) begin
            w_next_state = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        w_next_state = (fade_cmd == c_CMD_OUT) ? c_FADE_OUT : c_FADE_IN;
                    end
                end
                c_FADE_OUT, c_FADE_IN: begin
                    if (w_reach) begin
                        w_next_state = c_IDLE;
                    end
                end
                default: w_next_state = c_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy = (r_state != c_IDLE);
    end

    // Snap overrides any step or completion landing in the same cycle
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_level <= '0;
            r_tick  <= '0;
            r_done  <= 1'b0;
        end else if (w_snap) begin
            r_level <= c_FULL;
            r_tick  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_noop_done || w_reach;
            if (w_start) begin
                r_tick <= '0;
            end else if (w_busy && frame_tick) begin
                r_tick <= w_rate_hit ? 8'd0 : (r_tick + 8'd1);
            end
            if (w_step) begin
                r_level <= w_level_step;
            end
        end
    end

    assign level     = r_level;
    assign busy      = w_busy;
    assign fade_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_palette_fade_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_palette_fade_ram
// Purpose  : Directed bench for palette_fade_ram with a cycle-level reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_palette_fade_ram;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_index = '0;
    logic [11:0] wr_rgb = '0;
    logic        rd_valid = 1'b0;
    logic [3:0]  rd_index = '0;
    logic        out_valid;
    logic [3:0]  red, green, blue;
    logic        frame_tick = 1'b0;
    logic [1:0]  fade_cmd = 2'b00;
    logic [7:0]  fade_rate = 8'd1;
    logic [4:0]  level;
    logic        busy;
    logic        fade_done;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    // Reference state: palette contents, level, fade mode, tick count, pipeline
    int m_pal [16];
    int m_level = 0;
    int m_mode  = 0;
    int m_ticks = 0;
    int m_done  = 0;
    int m_p1v   = 0;
    int m_p1rgb = 0;
    int m_ov    = 0;
    int m_r = 0, m_g = 0, m_b = 0;

    palette_fade_ram #(.IDX_W(4), .CH_W(4), .LVL_W(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .wr_en(wr_en), .wr_index(wr_index), .wr_rgb(wr_rgb),
        .rd_valid(rd_valid), .rd_index(rd_index),
        .out_valid(out_valid), .red(red), .green(green), .blue(blue),
        .frame_tick(frame_tick), .fade_cmd(fade_cmd), .fade_rate(fade_rate),
        .level(level), .busy(busy), .fade_done(fade_done)
    );

    always #5 Clk = ~Clk;

    initial begin
        for (int i = 0; i < 16; i++) m_pal[i] = 0;
    end

    always @(negedge Reset_n) begin
        for (int i = 0; i < 16; i++) m_pal[i] = 0;
        m_level = 0; m_mode = 0; m_ticks = 0; m_done = 0;
        m_p1v = 0; m_p1rgb = 0; m_ov = 0; m_r = 0; m_g = 0; m_b = 0;
    end

    always @(posedge Clk) begin
        if (Reset_n) begin
            int rate;
            m_ov = m_p1v;
            if (m_p1v != 0) begin
                m_r = ((m_p1rgb >> 8) & 15) * m_level / 16;
                m_g = ((m_p1rgb >> 4) & 15) * m_level / 16;
                m_b = (m_p1rgb & 15) * m_level / 16;
            end
            m_p1v = int'(rd_valid);
            if (rd_valid)
                m_p1rgb = (wr_en && wr_index == rd_index) ? int'(wr_rgb) : m_pal[rd_index];
            if (wr_en) m_pal[wr_index] = int'(wr_rgb);
            rate = (fade_rate == 0) ? 1 : int'(fade_rate);
            m_done = 0;
            if (fade_cmd == 2'b11) begin
                m_level = 16; m_mode = 0; m_ticks = 0;
            end else if (m_mode == 0) begin
                if (fade_cmd == 2'b01) begin
                    if (m_level == 0) m_done = 1; else begin m_mode = 1; m_ticks = 0; end
                end else if (fade_cmd == 2'b10) begin
                    if (m_level == 16) m_done = 1; else begin m_mode = 2; m_ticks = 0; end
                end
            end else if (frame_tick) begin
                m_ticks++;
                if (m_ticks >= rate) begin
                    m_ticks = 0;
                    m_level += (m_mode == 1) ? -1 : 1;
                    if ((m_mode == 1 && m_level == 0) || (m_mode == 2 && m_level == 16)) begin
                        m_mode = 0; m_done = 1;
                    end
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (fade_done === 1'b1) done_cnt++;
        if (chk_en) begin
            checks++;
            if (out_valid !== m_ov[0] || red !== m_r[3:0] || green !== m_g[3:0] ||
                blue !== m_b[3:0] || level !== m_level[4:0] ||
                busy !== (m_mode != 0) || fade_done !== m_done[0]) begin
                fails++;
                $display("FAIL cycle_model t=%0t got v=%b rgb=%h%h%h lvl=%0d busy=%b done=%b want v=%0d rgb=%0h%0h%0h lvl=%0d busy=%0d done=%0d",
                         $time, out_valid, red, green, blue, level, busy, fade_done,
                         m_ov, m_r, m_g, m_b, m_level, (m_mode != 0), m_done);
            end else begin
                passes++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    task automatic read_idx(input int idx);
        rd_valid = 1'b1;
        rd_index = 4'(idx);
        cyc();
        rd_valid = 1'b0;
        cyc();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("reset_level", int'(level), 0);
        check("reset_valid", int'(out_valid), 0);
        check("reset_busy_done", int'({busy, fade_done}), 0);
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        chk_en = 1'b1;

        read_idx(5);
        check("post_reset_read_valid", int'(out_valid), 1);
        check("post_reset_read_rgb", int'({red, green, blue}), 0);

        fade_cmd = 2'b01;
        cyc();
        fade_cmd = 2'b00;
        check("noop_fadeout_done", int'(fade_done), 1);
        check("noop_fadeout_busy", int'(busy), 0);

        wr_en = 1'b1; wr_index = 4'd3; wr_rgb = 12'h377; fade_cmd = 2'b11;
        cyc();
        wr_en = 1'b0; fade_cmd = 2'b00;
        read_idx(3);
        check("snap_read_rgb", int'({red, green, blue}), 12'h377);
        check("snap_level", int'(level), 16);

        wr_en = 1'b1; wr_index = 4'd1; wr_rgb = 12'hF31;
        fade_rate = 8'd0; fade_cmd = 2'b01;
        cyc();
        wr_en = 1'b0; fade_cmd = 2'b00;
        repeat (8) tick();
        check("half_level", int'(level), 8);
        read_idx(1);
        check("half_rgb", int'({red, green, blue}), 12'h710);

        fade_cmd = 2'b11; frame_tick = 1'b1;
        cyc();
        fade_cmd = 2'b00; frame_tick = 1'b0;
        check("snap_over_step_level", int'(level), 16);
        check("snap_over_step_busy", int'(busy), 0);

        wr_en = 1'b1; wr_index = 4'd9; wr_rgb = 12'hABC;
        rd_valid = 1'b1; rd_index = 4'd9;
        cyc();
        wr_en = 1'b0; rd_valid = 1'b0;
        cyc();
        check("bypass_rgb", int'({red, green, blue}), 12'hABC);

        done_cnt = 0;
        fade_rate = 8'd2; fade_cmd = 2'b01;
        cyc();
        fade_cmd = 2'b00;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 5) begin
                fade_cmd = 2'b01;
                cyc();
                fade_cmd = 2'b00;
            end
            if (i == 16) check("fadeout_mid_level", int'(level), 8);
        end
        cyc();
        check("fadeout_end_level", int'(level), 0);
        check("fadeout_end_busy", int'(busy), 0);
        check("fadeout_done_count", done_cnt, 1);

        done_cnt = 0;
        fade_rate = 8'd1; fade_cmd = 2'b10;
        cyc();
        fade_cmd = 2'b00;
        repeat (16) tick();
        check("fadein_level", int'(level), 16);
        check("fadein_done_count", done_cnt, 1);

        fade_cmd = 2'b01;
        cyc();
        fade_cmd = 2'b00;
        repeat (6) tick();
        check("pre_reset_level", int'(level), 10);
        done_cnt = 0;
        rd_valid = 1'b1; rd_index = 4'd9;
        cyc();
        #2 Reset_n = 1'b0;
        #1;
        check("async_reset_level", int'(level), 0);
        check("async_reset_outs", int'({out_valid, busy, fade_done, red, green, blue}), 0);
        rd_valid = 1'b0;
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        repeat (4) begin
            cyc();
            check("no_stale_valid", int'(out_valid), 0);
        end
        check("reset_no_done", done_cnt, 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/palette_fade_ram.md
PALETTE_FADE_RAM -- requirements
Module: palette_fade_ram

Interface
REQ-001 SHALL have parameter IDX_W, default 4, palette index width; depth = 2^IDX_W entries.
REQ-002 SHALL have parameter CH_W, default 4, bits per colour channel; entry width = 3*CH_W, packed {red, green, blue}.
REQ-003 SHALL have parameter LVL_W, default 4, fade resolution; level range 0..2^LVL_W, with full brightness FULL = 2^LVL_W.
REQ-004 SHALL have port Clk  input  1  the single system clock; all state on rising edge.
REQ-005 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports wr_en  input  1, wr_index  input  IDX_W, wr_rgb  input  3*CH_W; together they form the palette write port.
REQ-007 SHALL have ports rd_valid  input  1 and rd_index  input  IDX_W; together they form the lookup request.
REQ-008 SHALL have ports out_valid  output  1 and red, green, blue  output  CH_W each; together they form the scaled lookup result.
REQ-009 SHALL have port frame_tick  input  1, a one-cycle pulse per video frame.
REQ-010 SHALL have port fade_cmd  input  2: 00 none, 01 fade-out, 10 fade-in, 11 snap-to-full.
REQ-011 SHALL have port fade_rate  input  8, the number of frame_ticks per level step; 0 is treated as 1.
REQ-012 SHALL have ports level  output  LVL_W+1, busy  output  1, and fade_done  output  1 (one-cycle pulse).

Function
REQ-013 SHALL write wr_rgb into entry wr_index on each Clk edge where wr_en=1.
REQ-014 SHALL implement the lookup as a 2-stage pipeline: stage 1 reads the entry; stage 2 scales it. out_valid and the colour outputs SHALL follow rd_valid and rd_index by exactly 2 cycles, one result per cycle, with no stalls.
REQ-015 SHALL return the newly written data when a read and a write to the same index occur in the same cycle (write-first bypass).
REQ-016 SHALL compute each channel as (c * L) >> LVL_W, where L is the level sampled in stage 2; the product SHALL be CH_W+LVL_W+1 bits wide, with no rounding. L = FULL SHALL yield c unchanged, and L = 0 SHALL yield 0.
REQ-017 SHALL hold red, green and blue at their last values while out_valid=0.
REQ-018 SHALL implement fade states IDLE, FADE_OUT and FADE_IN; busy=1 exactly when the state is not IDLE.
REQ-019 In IDLE, fade_cmd=01 SHALL enter FADE_OUT and fade_cmd=10 SHALL enter FADE_IN; both SHALL clear the tick counter.
REQ-020 In IDLE, a fade command whose target already equals level (0 for fade-out, FULL for fade-in) SHALL leave the state in IDLE and pulse fade_done on the next cycle.
REQ-021 In a fade state, every max(fade_rate,1)-th frame_tick SHALL step level by 1: decrement in FADE_OUT, increment in FADE_IN.
REQ-022 The step that reaches the target SHALL return the state to IDLE, and fade_done SHALL pulse on the following cycle; level SHALL never pass below 0 or above FULL.
REQ-023 Commands 01/10 received while busy SHALL be ignored.
REQ-024 fade_cmd=11 in any state SHALL set level=FULL, enter IDLE and clear the tick counter on the next edge, with no fade_done pulse; it SHALL take priority over a same-cycle step.
REQ-025 The step counter SHALL advance only on frame_tick; a fade_rate change mid-fade SHALL take effect at the next compare.

Reset
REQ-026 Reset_n=0 SHALL asynchronously clear all palette entries, both pipeline stages, out_valid, red, green, blue, the tick counter, level (0 = black), busy and fade_done, and SHALL set the state to IDLE.
REQ-027 Reset asserted mid-fade or mid-pipeline SHALL discard all in-flight work; the first out_valid after release SHALL correspond to a request made after release.

Verification (defaults IDX_W=4, CH_W=4, LVL_W=4)
REQ-028 Reset: assert Reset_n=0 asynchronously -> all outputs 0 and level=0 immediately; after release, read index 5 -> out_valid=1 two cycles later with rgb 0,0,0.
REQ-029 Write index 3 = 0x377, apply snap 11, read index 3 -> two cycles later rgb = 3,7,7.
REQ-030 Half brightness: with level=8 and index 1 = 0xF31, read index 1 -> rgb = 7,1,0.
REQ-031 Fade-out: from level=16 with fade_rate=2, issue 01 -> level steps every 2nd tick, reaching 0 after 32 ticks; fade_done pulses once, then busy=0; an 01 issued mid-fade has no effect.
REQ-032 Same-cycle write and read of index 9 with wr_rgb=0xABC at level 16 -> output rgb = A,B,C two cycles later.
REQ-033 Reset mid-fade at level 10 -> level=0, busy=0, no fade_done pulse, and no stale out_valid after release.
